roq_ld_sched: RTL

ROQ_LD_SCHED -- requirements
Module: roq_ld_sched

---
 rtl/roq_ld_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/roq_ld_sched.sv
// Load scheduler in front of a reorder queue: round-robin grants to four requesters,
// tracks request order so in-order ROQ data is steered back to the right requester.
module roq_ld_sched #(
    parameter int NREQ     = 4,
    parameter int MAX_OUTS = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      rq_vld,
    input  logic [NREQ*48-1:0]   rq_addr,
    output logic [NREQ-1:0]      rq_rdy,
    output logic                 mc_rd_rq,
    output logic [47:0]          mc_rq_vadr,
    output logic [7:0]           mc_rq_rtnctl,
    input  logic                 mc_rd_rq_stall,
    output logic                 roq_req_ld,
    input  logic [7:0]           roq_req_tid,
    input  logic                 roq_tid_avail,
    input  logic [63:0]          roq_dout,
    input  logic                 roq_dout_vld,
    output logic                 roq_pop,
    output logic [NREQ-1:0]      rs_vld,
    output logic [63:0]          rs_data,
    input  logic [NREQ-1:0]      rs_stall,
    output logic                 idle,
    output logic                 ord_err
);

    localparam logic [7:0] MAX_OUTS_C = 8'(MAX_OUTS);

    logic [1:0]      rr_ptr_q;
    logic [7:0]      outs_cnt_q [NREQ];
    logic [7:0]      outs_cnt_d [NREQ];
    logic [1:0]      ord_mem_q  [256];
    logic [7:0]      wr_ptr_q;
    logic [7:0]      rd_ptr_q;
    logic [8:0]      ord_cnt_q;
    logic            mc_rd_rq_q;
    logic [47:0]     mc_rq_vadr_q;
    logic [7:0]      mc_rq_rtnctl_q;
    logic [NREQ-1:0] rs_vld_q;
    logic [63:0]     rs_data_q;
    logic            ord_err_q;

    logic [NREQ-1:0] elig_s;
    logic            can_grant_s;
    logic            found_s;
    logic [1:0]      grant_id_s;
    logic [1:0]      head_id_s;
    logic            fifo_empty_s;
    logic            fifo_full_s;
    logic            pop_s;
    logic            outs_zero_s;

    assign fifo_empty_s = (ord_cnt_q == 9'd0);
    assign fifo_full_s  = (ord_cnt_q == 9'd256);
    assign head_id_s    = ord_mem_q[rd_ptr_q];
    // Grants and pops are forced off while reset is asserted, not just after it.
    assign can_grant_s  = reset_n && roq_tid_avail && !mc_rd_rq_stall && !fifo_full_s;
    assign pop_s        = reset_n && roq_dout_vld && !fifo_empty_s && !rs_stall[head_id_s];

    // Eligibility, next outstanding counts and the all-zero summary for idle.
    always_comb begin
        outs_zero_s = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i]     = rq_vld[i] && (outs_cnt_q[i] < MAX_OUTS_C);
            outs_cnt_d[i] = outs_cnt_q[i]
                          + (((found_s && grant_id_s == 2'(i))) ? 8'd1 : 8'd0)
                          - (((pop_s && head_id_s == 2'(i))) ? 8'd1 : 8'd0);
            outs_zero_s   = outs_zero_s & (outs_cnt_q[i] == 8'd0);
        end
    end

    // Round-robin search starting at rr_ptr; first eligible requester wins.
    always_comb begin : arb
        logic [1:0] idx_v;
        logic       hit_v;
        found_s    = 1'b0;
        grant_id_s = 2'd0;
        idx_v      = 2'd0;
        hit_v      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v      = rr_ptr_q + 2'(k);
            hit_v      = can_grant_s && elig_s[idx_v] && !found_s;
            grant_id_s = hit_v ? idx_v : grant_id_s;
            found_s    = found_s | hit_v;
        end
    end

    // Order FIFO storage; contents are only read while the count is non-zero.
    always_ff @(posedge clk) begin
        if (found_s) begin
            ord_mem_q[wr_ptr_q] <= grant_id_s;
        end else begin
            ord_mem_q[wr_ptr_q] <= ord_mem_q[wr_ptr_q];
        end
    end

    // Scheduler state and registered memory/return outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q       <= 2'd0;
            wr_ptr_q       <= 8'd0;
            rd_ptr_q       <= 8'd0;
            ord_cnt_q      <= 9'd0;
            mc_rd_rq_q     <= 1'b0;
            mc_rq_vadr_q   <= 48'd0;
            mc_rq_rtnctl_q <= 8'd0;
            rs_vld_q       <= '0;
            rs_data_q      <= 64'd0;
            ord_err_q      <= 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                outs_cnt_q[i] <= 8'd0;
            end
        end else begin
            rr_ptr_q   <= found_s ? (grant_id_s + 2'd1) : rr_ptr_q;
            wr_ptr_q   <= wr_ptr_q + (found_s ? 8'd1 : 8'd0);
            rd_ptr_q   <= rd_ptr_q + (pop_s ? 8'd1 : 8'd0);
            ord_cnt_q  <= ord_cnt_q + (found_s ? 9'd1 : 9'd0) - (pop_s ? 9'd1 : 9'd0);
            mc_rd_rq_q <= found_s;
            if (found_s) begin
                mc_rq_vadr_q   <= rq_addr[48*int'(grant_id_s) +: 48];
                mc_rq_rtnctl_q <= roq_req_tid;
            end else begin
                mc_rq_vadr_q   <= mc_rq_vadr_q;
                mc_rq_rtnctl_q <= mc_rq_rtnctl_q;
            end
            rs_vld_q  <= pop_s ? (NREQ'(1) << head_id_s) : '0;
            rs_data_q <= pop_s ? roq_dout : rs_data_q;
            ord_err_q <= ord_err_q | (roq_dout_vld && fifo_empty_s);
            for (int i = 0; i < NREQ; i++) begin
                outs_cnt_q[i] <= outs_cnt_d[i];
            end
        end
    end

    assign rq_rdy       = found_s ? (NREQ'(1) << grant_id_s) : '0;
    assign roq_req_ld   = found_s;
    assign roq_pop      = pop_s;
    assign mc_rd_rq     = mc_rd_rq_q;
    assign mc_rq_vadr   = mc_rq_vadr_q;
    assign mc_rq_rtnctl = mc_rq_rtnctl_q;
    assign rs_vld       = rs_vld_q;
    assign rs_data      = rs_data_q;
    assign ord_err      = ord_err_q;
    assign idle         = fifo_empty_s && outs_zero_s && (rs_vld_q == '0);

endmodule
